// File: rtl/cu_mem_pkg.sv
// Shared encodings between the control unit and the memory stage.
//   - Data size encodings driven on ramDataSize (2'b11 is handled as a word).
//   - Read/write encodings driven on ramRW.
//   - Memory-stage FSM states.
//   - Helpers for the misalignment check and byte-lane masks.
// Byte lane 0 always addresses mem[A], lane 3 addresses mem[A+3].
package cu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ramStateT;

    // Halfwords need an even address, words (and size 11) a multiple of four.
    function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
        logic result;
        case (size)
            SZ_BYTE: result = 1'b0;
            SZ_HALF: result = addrLow[0];
            default: result = |addrLow;
        endcase
        return result;
    endfunction

    // Lanes touched by an access of the given size, starting at lane 0.
    function automatic logic [3:0] laneMask(input logic [1:0] size);
        logic [3:0] result;
        case (size)
            SZ_BYTE: result = 4'b0001;
            SZ_HALF: result = 4'b0011;
            default: result = 4'b1111;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ram_byte_array.sv
// Byte-wide storage of 2**ADDR_W bytes with four byte-lane ports.
//   clk     : clock, rising edge (no reset: contents survive reset)
//   addr    : base byte address A; lane i addresses A+i
//   wrMask  : per-lane write enable, bit i -> lane i
//   wrData  : write data, lane i in bits [31-8i -: 8] (lane 0 = MSB byte)
//   rdData  : read data, same lane packing as wrData
// Read ports are combinational; the controller registers the steered
// result into its dataOut register.
module ram_byte_array #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        wrMask,
    input  logic [31:0]       wrData,
    output logic [31:0]       rdData
);

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] laneAddr [0:3];

    // Lane addresses wrap naturally at the array size; aligned accesses
    // never actually reach the wrap point.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            assign laneAddr[gi]          = addr + ADDR_W'(gi);
            assign rdData[31-8*gi -: 8]  = mem[laneAddr[gi]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wrMask[i]) begin
                mem[laneAddr[i]] <= wrData[31-8*i -: 8];
            end
        end
    end

endmodule

// File: rtl/ram_access_controller.sv
// Memory stage behind the control unit: owns the big-endian byte RAM and
// serves ramMFA/ramRW/ramDataSize/ramAddress requests with a ramMFC
// handshake.
//   Clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   ramMFA      : request valid, held until ramMFC is seen
//   ramRW       : 1 = read, 0 = write
//   ramDataSize : 00 byte, 01 halfword, 10/11 word
//   ramAddress  : byte address
//   dataIn      : write data (byte in [7:0], halfword in [15:0])
//   dataOut     : read data, zero-extended for byte/halfword
//   ramMFC      : memory function complete
//   alignErr    : misaligned request flag, valid while ramMFC = 1
// Request values are captured in IDLE; WAIT counts down WAIT_CYCLES edges
// and performs the access on the last one; ramMFC is raised from DONE one
// edge later, giving WAIT_CYCLES+1 edges from the sampling edge to ramMFC.
module ram_access_controller
    import cu_mem_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              ramMFA,
    input  logic              ramRW,
    input  logic [1:0]        ramDataSize,
    input  logic [ADDR_W-1:0] ramAddress,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              ramMFC,
    output logic              alignErr
);

    ramStateT          stateReg, stateNext;
    logic [3:0]        cntReg, cntNext;
    logic              latchReq;
    logic              doAccess;
    logic              mfcNext;
    logic              errNext;

    logic [ADDR_W-1:0] addrReg;
    logic [1:0]        sizeReg;
    logic              rwReg;
    logic [31:0]       dataInReg;
    logic              errPendReg;
    logic [DATA_W-1:0] dataOutReg;
    logic              mfcReg;
    logic              alignErrReg;

    logic [3:0]        wrMask;
    logic [31:0]       wrData;
    logic [31:0]       rdData;
    logic [31:0]       readValue;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
            cntReg   <= '0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        latchReq  = 1'b0;
        doAccess  = 1'b0;
        mfcNext   = 1'b0;
        errNext   = 1'b0;
        case (stateReg)
            IDLE: begin
                if (ramMFA) begin
                    latchReq  = 1'b1;
                    cntNext   = 4'(WAIT_CYCLES - 1);
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                // Dropping MFA here abandons the request before anything
                // is committed.
                if (!ramMFA) begin
                    stateNext = IDLE;
                end else if (cntReg == 4'd0) begin
                    doAccess  = 1'b1;
                    stateNext = DONE;
                end else begin
                    cntNext = cntReg - 4'd1;
                end
            end
            DONE: begin
                if (ramMFA) begin
                    mfcNext = 1'b1;
                    errNext = errPendReg;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            addrReg    <= '0;
            sizeReg    <= SZ_BYTE;
            rwReg      <= RW_READ;
            dataInReg  <= '0;
            errPendReg <= 1'b0;
        end else if (latchReq) begin
            addrReg    <= ramAddress;
            sizeReg    <= ramDataSize;
            rwReg      <= ramRW;
            dataInReg  <= dataIn[31:0];
            errPendReg <= isMisaligned(ramDataSize, ramAddress[1:0]);
        end
    end

    // ---------------- lane steering ----------------
    // Big-endian: the most significant byte of the access lands at mem[A],
    // which is lane 0 (top byte of wrData/rdData).
    always_comb begin
        case (sizeReg)
            SZ_BYTE: wrData = {dataInReg[7:0], 24'b0};
            SZ_HALF: wrData = {dataInReg[15:0], 16'b0};
            default: wrData = dataInReg;
        endcase
    end

    always_comb begin
        case (sizeReg)
            SZ_BYTE: readValue = {24'b0, rdData[31:24]};
            SZ_HALF: readValue = {16'b0, rdData[31:16]};
            default: readValue = rdData;
        endcase
    end

    // Reset gates the write so an access edge coinciding with reset is lost.
    assign wrMask = (doAccess && (rwReg == RW_WRITE) && !errPendReg && !reset)
                    ? laneMask(sizeReg) : 4'b0000;

    ram_byte_array #(
        .ADDR_W(ADDR_W)
    ) uArray (
        .clk    (Clk),
        .addr   (addrReg),
        .wrMask (wrMask),
        .wrData (wrData),
        .rdData (rdData)
    );

    // ---------------- outputs ----------------
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            dataOutReg  <= '0;
            mfcReg      <= 1'b0;
            alignErrReg <= 1'b0;
        end else begin
            mfcReg      <= mfcNext;
            alignErrReg <= errNext;
            // A misaligned read leaves the previous read data in place.
            if (doAccess && (rwReg == RW_READ) && !errPendReg) begin
                dataOutReg <= DATA_W'(readValue);
            end
        end
    end

    assign dataOut  = dataOutReg;
    assign ramMFC   = mfcReg;
    assign alignErr = alignErrReg;

endmodule

// File: tb/tb_ram_access_controller.sv
// Directed bench for ram_access_controller with WAIT_CYCLES = 3.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge. Expected values are hand-computed from the big-endian
// memory contents written earlier in the sequence.
module tb_ram_access_controller;
    import cu_mem_pkg::*;

    localparam int W = 3;

    logic        Clk = 1'b0;
    logic        reset;
    logic        ramMFA;
    logic        ramRW;
    logic [1:0]  ramDataSize;
    logic [8:0]  ramAddress;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        ramMFC;
    logic        alignErr;

    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] expOut;

    always #5 Clk = ~Clk;

    ram_access_controller #(
        .ADDR_W(9),
        .WAIT_CYCLES(W),
        .DATA_W(32)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .ramMFA     (ramMFA),
        .ramRW      (ramRW),
        .ramDataSize(ramDataSize),
        .ramAddress (ramAddress),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .ramMFC     (ramMFC),
        .alignErr   (alignErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Full handshake: raise MFA, wait for ramMFC, hold one more edge, drop MFA.
    task automatic access(input string tag, input logic rw, input logic [1:0] sz,
                          input logic [8:0] addr, input logic [31:0] din,
                          input logic [31:0] expData, input logic expErr);
        int lat;
        bit seen;
        @(negedge Clk);
        ramRW = rw; ramDataSize = sz; ramAddress = addr; dataIn = din; ramMFA = 1'b1;
        lat  = -1;  // first rising edge is the one that samples the request
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge Clk); #1;
            lat++;
            if (ramMFC) seen = 1;
        end
        check({tag, ".latency"}, 32'(lat), 32'(W + 1));
        check({tag, ".data"}, dataOut, expData);
        check({tag, ".err"}, 32'(alignErr), 32'(expErr));
        // Inputs changing while MFA is held must not matter.
        @(negedge Clk);
        ramAddress = 9'h1FF; dataIn = 32'h0; ramDataSize = SZ_BYTE;
        @(posedge Clk); #1;
        check({tag, ".holdMfc"}, 32'(ramMFC), 32'd1);
        check({tag, ".holdData"}, dataOut, expData);
        @(negedge Clk);
        ramMFA = 1'b0;
        @(posedge Clk); #1;
        check({tag, ".clrMfc"}, 32'(ramMFC), 32'd0);
        check({tag, ".clrErr"}, 32'(alignErr), 32'd0);
        $display("txn %s rw=%0d sz=%0d addr=%0d din=%h dout=%h lat=%0d", tag, rw, sz, addr, din,
                 expData, lat);
    endtask

    initial begin
        reset = 1'b1; ramMFA = 1'b0; ramRW = RW_READ; ramDataSize = SZ_BYTE;
        ramAddress = '0; dataIn = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset.mfc", 32'(ramMFC), 32'd0);
        check("reset.err", 32'(alignErr), 32'd0);
        check("reset.data", dataOut, 32'd0);
        @(negedge Clk);
        reset = 1'b0;
        expOut = 32'd0;

        // Preload and word read-back
        access("wrWord0", RW_WRITE, SZ_WORD, 9'd0, 32'h8C22_0004, expOut, 1'b0);
        expOut = 32'h8C22_0004;
        access("rdWord0", RW_READ, SZ_WORD, 9'd0, 32'h0, expOut, 1'b0);

        // Byte write into the middle of a known word
        access("wrWord4", RW_WRITE, SZ_WORD, 9'd4, 32'h1122_3344, expOut, 1'b0);
        access("wrByte7", RW_WRITE, SZ_BYTE, 9'd7, 32'hFFFF_FFA5, expOut, 1'b0);
        expOut = 32'h0000_33A5;
        access("rdHalf6", RW_READ, SZ_HALF, 9'd6, 32'h0, expOut, 1'b0);
        expOut = 32'h0000_00A5;
        access("rdByte7", RW_READ, SZ_BYTE, 9'd7, 32'h0, expOut, 1'b0);
        expOut = 32'h1122_33A5;
        access("rdWord4", RW_READ, SZ_WORD, 9'd4, 32'h0, expOut, 1'b0);

        // Word write, size 11 read, halfword write
        access("wrWord8", RW_WRITE, SZ_WORD, 9'd8, 32'hDEAD_BEEF, expOut, 1'b0);
        expOut = 32'hDEAD_BEEF;
        access("rdSz3_8", RW_READ, 2'b11, 9'd8, 32'h0, expOut, 1'b0);
        access("wrHalf10", RW_WRITE, SZ_HALF, 9'd10, 32'h1234_CAFE, expOut, 1'b0);
        expOut = 32'hDEAD_CAFE;
        access("rdWord8", RW_READ, SZ_WORD, 9'd8, 32'h0, expOut, 1'b0);

        // Misaligned requests: flag set, data and memory untouched
        access("rdHalf5", RW_READ, SZ_HALF, 9'd5, 32'h0, expOut, 1'b1);
        access("wrWord2", RW_WRITE, SZ_WORD, 9'd2, 32'h1234_5678, expOut, 1'b1);
        expOut = 32'h8C22_0004;
        access("rdWord0b", RW_READ, SZ_WORD, 9'd0, 32'h0, expOut, 1'b0);
        expOut = 32'h1122_33A5;
        access("rdWord4b", RW_READ, SZ_WORD, 9'd4, 32'h0, expOut, 1'b0);

        // Aborted write: MFA dropped after one WAIT cycle
        access("wrWord12", RW_WRITE, SZ_WORD, 9'd12, 32'h0BAD_F00D, expOut, 1'b0);
        begin
            bit mfcSeen;
            mfcSeen = 0;
            @(negedge Clk);
            ramRW = RW_WRITE; ramDataSize = SZ_WORD; ramAddress = 9'd12;
            dataIn = 32'h5555_5555; ramMFA = 1'b1;
            @(posedge Clk);      // sampling edge
            @(posedge Clk);      // one WAIT cycle
            @(negedge Clk);
            ramMFA = 1'b0;
            for (int i = 0; i < 6; i++) begin
                @(posedge Clk); #1;
                if (ramMFC) mfcSeen = 1;
            end
            check("abort.mfcNeverRose", 32'(mfcSeen), 32'd0);
            $display("txn abort wr addr=12 din=55555555");
        end
        expOut = 32'h0BAD_F00D;
        access("rdAfterAbort", RW_READ, SZ_WORD, 9'd12, 32'h0, expOut, 1'b0);

        // Reset pulsed during WAIT of a write
        @(negedge Clk);
        ramRW = RW_WRITE; ramDataSize = SZ_WORD; ramAddress = 9'd12;
        dataIn = 32'h9999_9999; ramMFA = 1'b1;
        @(posedge Clk);          // sampling edge
        @(posedge Clk);
        #2 reset = 1'b1;
        #1;
        check("rstMid.mfc", 32'(ramMFC), 32'd0);
        check("rstMid.data", dataOut, 32'd0);
        @(negedge Clk);
        ramMFA = 1'b0;
        @(negedge Clk);
        reset = 1'b0;
        $display("txn resetDuringWrite addr=12 din=99999999");
        expOut = 32'h0BAD_F00D;
        access("rdAfterRst12", RW_READ, SZ_WORD, 9'd12, 32'h0, expOut, 1'b0);
        expOut = 32'h8C22_0004;
        access("rdAfterRst0", RW_READ, SZ_WORD, 9'd0, 32'h0, expOut, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
